rf_hazard_ctrl: RTL and testbench

- Hazard scheduler for the 32x32 register file in the 5-stage MIPS pipeline (D/E/M/W).
- Keeps a shadow pipeline of in-flight RF writes (destination, write-enable, Tnew) for the E, M and W stages.
- From that state it decides D-stage stall and bubble insertion, and generates forwarding selects for D-stage and E-stage operand reads.
- The register file writes on the clock edge with no internal bypass, so every W-stage result must also be forwarded.

---
 rtl/rf_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_rf_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rf_hazard_ctrl.sv
// Register-file hazard scheduler for the 5-stage MIPS pipeline: tracks in-flight
// writes in E/M/W, raises D-stage stalls and drives D/E operand forwarding selects.
module rf_hazard_ctrl #(
  parameter logic [1:0]  TUSE_NONE = 2'd3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [4:0]       d_dst,
  input  logic             d_we,
  input  logic [1:0]       d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]       e_dst_q, e_rs_q, e_rt_q, m_dst_q, w_dst_q;
  logic             e_we_q, m_we_q, w_we_q;
  logic [1:0]       e_tnew_q, m_tnew_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0]       e_dst_d, e_rs_d, e_rt_d, m_dst_d, w_dst_d;
  logic             e_we_d, m_we_d, w_we_d;
  logic [1:0]       e_tnew_d, m_tnew_d;
  logic [CNT_W-1:0] cnt_d;

  logic [4:0]       e_wdst_s, m_wdst_s, w_wdst_s;
  logic             stall_rs_s, stall_rt_s;

  // A stage that does not write is folded into destination 0, which never matches.
  assign e_wdst_s = e_we_q ? e_dst_q : 5'd0;
  assign m_wdst_s = m_we_q ? m_dst_q : 5'd0;
  assign w_wdst_s = w_we_q ? w_dst_q : 5'd0;

  function automatic logic need_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input logic [4:0] ed, input logic [1:0] et,
                                      input logic [4:0] md, input logic [1:0] mt);
    return (tuse != TUSE_NONE) && (r != 5'd0) &&
           (((ed == r) && (et > tuse)) || ((md == r) && (mt > tuse)));
  endfunction

  // A younger matching stage that is not ready hides older copies of the register.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] r,
                                           input logic [4:0] ed, input logic [1:0] et,
                                           input logic [4:0] md, input logic [1:0] mt,
                                           input logic [4:0] wd);
    logic [1:0] sel;
    if (r == 5'd0)       sel = 2'd0;
    else if (ed == r)    sel = (et == 2'd0) ? 2'd1 : 2'd0;
    else if (md == r)    sel = (mt == 2'd0) ? 2'd2 : 2'd0;
    else if (wd == r)    sel = 2'd3;
    else                 sel = 2'd0;
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] r,
                                           input logic [4:0] md, input logic [1:0] mt,
                                           input logic [4:0] wd);
    logic [1:0] sel;
    if (r == 5'd0)       sel = 2'd0;
    else if (md == r)    sel = (mt == 2'd0) ? 2'd2 : 2'd0;
    else if (wd == r)    sel = 2'd3;
    else                 sel = 2'd0;
    return sel;
  endfunction

  always_comb begin
    stall_rs_s = need_stall(d_rs, d_tuse_rs, e_wdst_s, e_tnew_q, m_wdst_s, m_tnew_q);
    stall_rt_s = need_stall(d_rt, d_tuse_rt, e_wdst_s, e_tnew_q, m_wdst_s, m_tnew_q);
    stall      = stall_rs_s | stall_rt_s;
    fwd_d_rs   = fwd_d_sel(d_rs, e_wdst_s, e_tnew_q, m_wdst_s, m_tnew_q, w_wdst_s);
    fwd_d_rt   = fwd_d_sel(d_rt, e_wdst_s, e_tnew_q, m_wdst_s, m_tnew_q, w_wdst_s);
    fwd_e_rs   = fwd_e_sel(e_rs_q, m_wdst_s, m_tnew_q, w_wdst_s);
    fwd_e_rt   = fwd_e_sel(e_rt_q, m_wdst_s, m_tnew_q, w_wdst_s);
  end

  assign stall_cnt = cnt_q;

  always_comb begin
    w_dst_d  = m_dst_q;
    w_we_d   = m_we_q;
    m_dst_d  = e_dst_q;
    m_we_d   = e_we_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : (e_tnew_q - 2'd1);
    if (stall) begin
      e_dst_d  = 5'd0;
      e_we_d   = 1'b0;
      e_tnew_d = 2'd0;
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
    end else begin
      e_dst_d  = d_dst;
      e_we_d   = d_we;
      e_tnew_d = d_tnew;
      e_rs_d   = d_rs;
      e_rt_d   = d_rt;
    end
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_q  <= 5'd0;
      e_we_q   <= 1'b0;
      e_tnew_q <= 2'd0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      m_dst_q  <= 5'd0;
      m_we_q   <= 1'b0;
      m_tnew_q <= 2'd0;
      w_dst_q  <= 5'd0;
      w_we_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      e_dst_q  <= e_dst_d;
      e_we_q   <= e_we_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_dst_q  <= m_dst_d;
      m_we_q   <= m_we_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      w_we_q   <= w_we_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Scoreboard bench for rf_hazard_ctrl: directed instruction sequences with
// hand-computed expected stall/forward/counter values, plus a 2-bit counter instance.
module tb_rf_hazard_ctrl;

  localparam logic [1:0] N = 2'd3;

  typedef struct packed {
    logic [7:0]  id;
    logic        chk;
    logic        stall;
    logic [1:0]  fdrs, fdrt, fers, fert;
    logic [31:0] cnt;
  } exp_t;

  logic        clk, reset;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_we;
  logic        stall, stall2;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [1:0]  fwd_d_rs2, fwd_d_rt2, fwd_e_rs2, fwd_e_rt2;
  logic [31:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] vec_id = 8'd0;

  rf_hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_we(d_we),
    .d_tnew(d_tnew), .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .stall_cnt(stall_cnt)
  );

  rf_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_we(d_we),
    .d_tnew(d_tnew), .stall(stall2), .fwd_d_rs(fwd_d_rs2), .fwd_d_rt(fwd_d_rt2),
    .fwd_e_rs(fwd_e_rs2), .fwd_e_rt(fwd_e_rt2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] id,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0d, expected %0d", nm, id, act, req);
    end
  endtask

  // Drive one D-stage vector just after the clock edge and queue its expected outputs.
  task automatic v(input logic rst,
                   input logic [4:0] rs, input logic [1:0] trs,
                   input logic [4:0] rt, input logic [1:0] trt,
                   input logic [4:0] dst, input logic we, input logic [1:0] tnew,
                   input logic chk, input logic st,
                   input logic [1:0] fdrs, input logic [1:0] fdrt,
                   input logic [1:0] fers, input logic [1:0] fert,
                   input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_dst = dst; d_we = we; d_tnew = tnew;
    e.id = vec_id; e.chk = chk; e.stall = st;
    e.fdrs = fdrs; e.fdrt = fdrt; e.fers = fers; e.fert = fert; e.cnt = cnt;
    exp_q.push_back(e);
    vec_id = vec_id + 8'd1;
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] sat;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        sat = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
        check("stall",     e.id, {31'd0, stall},    {31'd0, e.stall});
        check("fwd_d_rs",  e.id, {30'd0, fwd_d_rs}, {30'd0, e.fdrs});
        check("fwd_d_rt",  e.id, {30'd0, fwd_d_rt}, {30'd0, e.fdrt});
        check("fwd_e_rs",  e.id, {30'd0, fwd_e_rs}, {30'd0, e.fers});
        check("fwd_e_rt",  e.id, {30'd0, fwd_e_rt}, {30'd0, e.fert});
        check("stall_cnt", e.id, stall_cnt,         e.cnt);
        check("sat_outs",  e.id, {23'd0, stall2, fwd_d_rs2, fwd_d_rt2, fwd_e_rs2, fwd_e_rt2},
                                 {23'd0, e.stall, e.fdrs, e.fdrt, e.fers, e.fert});
        check("sat_cnt",   e.id, {30'd0, stall_cnt2}, sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; d_rs = 5'd5; d_tuse_rs = 2'd0; d_rt = 5'd0; d_tuse_rt = N;
    d_dst = 5'd0; d_we = 1'b0; d_tnew = 2'd0;
    // rst rs trs rt trt dst we tnew | chk stall fdrs fdrt fers fert cnt
    v(1, 5, 0, 0, N, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    v(1, 5, 0, 0, N, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    v(0, 5, 0, 0, N, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // load-use: lw $8 then addu reading $8 at tuse 1
    v(0, 29, 1, 0, N, 8, 1, 2,  1, 0, 0, 0, 0, 0, 0);
    v(0, 8, 1, 9, 1, 2, 1, 1,   1, 1, 0, 0, 0, 0, 0);
    v(0, 8, 1, 9, 1, 2, 1, 1,   1, 0, 0, 0, 0, 0, 1);
    v(0, 0, N, 0, N, 0, 0, 0,   1, 0, 0, 0, 3, 0, 1);
    // branch after ALU: addu $9 then beq $9,$2
    v(0, 0, N, 0, N, 9, 1, 1,   1, 0, 0, 0, 0, 0, 1);
    v(0, 9, 0, 2, 0, 0, 0, 0,   1, 1, 0, 3, 0, 0, 1);
    v(0, 9, 0, 2, 0, 0, 0, 0,   1, 0, 2, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 0, 0, 0,   1, 0, 0, 0, 3, 0, 2);
    // jal $31 then jr $31
    v(0, 0, N, 0, N, 31, 1, 0,  1, 0, 0, 0, 0, 0, 2);
    v(0, 31, 0, 0, N, 0, 0, 0,  1, 0, 1, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 0, 0, 0,   1, 0, 0, 0, 2, 0, 2);
    // three writes of $10, then sw reading $10 as rt at tuse 2
    v(0, 0, N, 0, N, 10, 1, 1,  1, 0, 0, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 10, 1, 1,  1, 0, 0, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 10, 1, 1,  1, 0, 0, 0, 0, 0, 2);
    v(0, 29, 1, 10, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 0, 0, 0,   1, 0, 0, 0, 0, 2, 2);
    v(0, 10, 0, 0, N, 0, 0, 0,  1, 0, 3, 0, 0, 0, 2);
    // lw $0 then read $0 at tuse 0
    v(0, 29, 1, 0, N, 0, 1, 2,  1, 0, 0, 0, 0, 0, 2);
    v(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2);
    // lw $8 then a TUSE_NONE reader of $8
    v(0, 29, 1, 0, N, 8, 1, 2,  1, 0, 0, 0, 0, 0, 2);
    v(0, 8, N, 8, N, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 0, 0, 0,   1, 0, 0, 0, 0, 0, 2);
    // reset asserted in the middle of a load-branch stall
    v(0, 0, N, 0, N, 8, 1, 2,   1, 0, 0, 0, 0, 0, 2);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2);
    v(1, 8, 0, 0, N, 0, 0, 0,   1, 1, 0, 0, 0, 0, 3);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // two load-branch pairs: two stall cycles each, 2-bit counter saturates at 3
    v(0, 0, N, 0, N, 8, 1, 2,   1, 0, 0, 0, 0, 0, 0);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 0, 3, 0, 0, 0, 2);
    v(0, 0, N, 0, N, 8, 1, 2,   1, 0, 0, 0, 0, 0, 2);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 1, 0, 0, 0, 0, 3);
    v(0, 8, 0, 0, N, 0, 0, 0,   1, 0, 3, 0, 0, 0, 4);
    v(0, 0, N, 0, N, 0, 0, 0,   1, 0, 0, 0, 0, 0, 4);
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", vec_id, exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
